// File: rtl/color_locator_pkg.sv
// Shared types for the colour-block locator.
// State encoding, RGB 3:3:3 field positions, cost width and cost helper.
package color_locator_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_COST,
    S_UPDATE,
    S_DONE
  } state_e;

  localparam int COST_W = 32;

  localparam int R_HI = 8;
  localparam int R_LO = 6;
  localparam int G_HI = 5;
  localparam int G_LO = 3;
  localparam int B_HI = 2;
  localparam int B_LO = 0;

  typedef struct packed {
    logic [COST_W-1:0] cost;
    logic [9:0]        x;
    logic [9:0]        y;
  } win_t;

  function automatic logic [COST_W-1:0] chan_cost(
    input logic [COST_W-1:0] a,
    input logic [COST_W-1:0] b,
    input logic [COST_W-1:0] c
  );
    if (a > b && a > c) return (a - b) * (a - c);
    return '0;
  endfunction

endpackage

// File: rtl/color_locator_block_accumulator.sv
// Per-block address generator and latency-aligned channel accumulator.
// Tags each address with valid/last bits delayed by MEM_LAT to match data.
module block_accumulator
  import color_locator_pkg::*;
#(
  parameter int BLK     = 4,
  parameter int MEM_LAT = 2,
  localparam int LB     = $clog2(BLK),
  localparam int SW     = 3 + 2 * LB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          fetch_i,
  input  logic [9:0]    bx_i,
  input  logic [9:0]    by_i,
  input  logic [8:0]    pixel_i,
  output logic [9:0]    hcount_o,
  output logic [9:0]    vcount_o,
  output logic [SW-1:0] sum_r_o,
  output logic [SW-1:0] sum_g_o,
  output logic [SW-1:0] sum_b_o,
  output logic          last_o
);

  localparam int PW = 2 * LB + 1;
  localparam logic [PW-1:0] NPIX = PW'(BLK * BLK);

  logic [PW-1:0]      pix_q;
  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] lst_q;
  logic [SW-1:0]      sr_q, sg_q, sb_q;
  logic               issue;
  logic               issue_last;

  assign issue      = fetch_i && (pix_q < NPIX);
  assign issue_last = issue && (pix_q == NPIX - 1'b1);

  assign hcount_o = issue ? 10'(bx_i << LB) + 10'(pix_q[LB-1:0]) : '0;
  assign vcount_o = issue ? 10'(by_i << LB) + 10'(pix_q[2*LB-1:LB]) : '0;

  assign sum_r_o = sr_q;
  assign sum_g_o = sg_q;
  assign sum_b_o = sb_q;
  assign last_o  = lst_q[MEM_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
      vld_q <= '0;
      lst_q <= '0;
      sr_q  <= '0;
      sg_q  <= '0;
      sb_q  <= '0;
    end else if (clr_i) begin
      pix_q <= '0;
      vld_q <= '0;
      lst_q <= '0;
      sr_q  <= '0;
      sg_q  <= '0;
      sb_q  <= '0;
    end else begin
      if (issue) pix_q <= pix_q + 1'b1;
      vld_q <= MEM_LAT'({vld_q, issue});
      lst_q <= MEM_LAT'({lst_q, issue_last});
      if (vld_q[MEM_LAT-1]) begin
        sr_q <= sr_q + SW'(pixel_i[R_HI:R_LO]);
        sg_q <= sg_q + SW'(pixel_i[G_HI:G_LO]);
        sb_q <= sb_q + SW'(pixel_i[B_HI:B_LO]);
      end
    end
  end

endmodule

// File: rtl/color_locator.sv
// Scans a frame block by block and keeps, per colour channel, the block
// with the highest dominance cost; results publish when the scan ends.
module color_locator
  import color_locator_pkg::*;
#(
  parameter int FRAME_W = 240,
  parameter int FRAME_H = 240,
  parameter int BLK     = 4,
  parameter int MARGIN  = 2,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] min_cost,
  input  logic [8:0]  mem_pixel_data,
  output logic        mem_request,
  output logic [9:0]  mem_hcount,
  output logic [9:0]  mem_vcount,
  output logic        busy,
  output logic        done,
  output logic [9:0]  red_x,
  output logic [9:0]  red_y,
  output logic [9:0]  green_x,
  output logic [9:0]  green_y,
  output logic [9:0]  blue_x,
  output logic [9:0]  blue_y,
  output logic [31:0] red_cost,
  output logic [31:0] green_cost,
  output logic [31:0] blue_cost,
  output logic [2:0]  found
);

  localparam int LB = $clog2(BLK);
  localparam int SW = 3 + 2 * LB;
  localparam logic [9:0] B_LO  = 10'(MARGIN);
  localparam logic [9:0] BX_HI = 10'(FRAME_W / BLK - 1 - MARGIN);
  localparam logic [9:0] BY_HI = 10'(FRAME_H / BLK - 1 - MARGIN);

  state_e                   state_q, state_d;
  logic [9:0]               bx_q, bx_d, by_q, by_d;
  logic [COST_W-1:0]        min_q, min_d;
  logic [2:0][COST_W-1:0]   cost_q, cost_d;
  win_t [2:0]               best_q, best_d;
  win_t [2:0]               out_q, out_d;
  logic [2:0]               found_q, found_d;

  logic          acc_clr;
  logic          acc_last;
  logic [SW-1:0] sr, sg, sb;
  logic          last_blk;
  logic [9:0]    blk_x, blk_y;

  block_accumulator #(
    .BLK     (BLK),
    .MEM_LAT (MEM_LAT)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (acc_clr),
    .fetch_i  (state_q == S_FETCH),
    .bx_i     (bx_q),
    .by_i     (by_q),
    .pixel_i  (mem_pixel_data),
    .hcount_o (mem_hcount),
    .vcount_o (mem_vcount),
    .sum_r_o  (sr),
    .sum_g_o  (sg),
    .sum_b_o  (sb),
    .last_o   (acc_last)
  );

  assign last_blk = (bx_q == BX_HI) && (by_q == BY_HI);
  assign blk_x    = 10'(bx_q << LB);
  assign blk_y    = 10'(by_q << LB);

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    min_d   = min_q;
    cost_d  = cost_q;
    best_d  = best_q;
    out_d   = out_q;
    found_d = found_q;
    acc_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          bx_d    = B_LO;
          by_d    = B_LO;
          min_d   = min_cost;
          best_d  = '0;
          acc_clr = 1'b1;
        end
      end
      S_FETCH: begin
        if (acc_last) state_d = S_COST;
      end
      S_COST: begin
        cost_d[0] = chan_cost(COST_W'(sr), COST_W'(sg), COST_W'(sb));
        cost_d[1] = chan_cost(COST_W'(sg), COST_W'(sr), COST_W'(sb));
        cost_d[2] = chan_cost(COST_W'(sb), COST_W'(sr), COST_W'(sg));
        state_d   = S_UPDATE;
      end
      S_UPDATE: begin
        for (int c = 0; c < 3; c++) begin
          if (cost_q[c] > best_q[c].cost) begin
            best_d[c].cost = cost_q[c];
            best_d[c].x    = blk_x;
            best_d[c].y    = blk_y;
          end
        end
        if (last_blk) begin
          state_d = S_DONE;
          out_d   = best_d;
          for (int c = 0; c < 3; c++) begin
            found_d[2-c] = (best_d[c].cost != '0) &&
                           (best_d[c].cost >= min_q);
          end
        end else begin
          state_d = S_FETCH;
          acc_clr = 1'b1;
          if (bx_q == BX_HI) begin
            bx_d = B_LO;
            by_d = by_q + 10'd1;
          end else begin
            bx_d = bx_q + 10'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      min_q   <= '0;
      cost_q  <= '0;
      best_q  <= '0;
      out_q   <= '0;
      found_q <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      min_q   <= min_d;
      cost_q  <= cost_d;
      best_q  <= best_d;
      out_q   <= out_d;
      found_q <= found_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign mem_request = busy;
  assign done        = (state_q == S_DONE);

  assign red_cost   = out_q[0].cost;
  assign red_x      = out_q[0].x;
  assign red_y      = out_q[0].y;
  assign green_cost = out_q[1].cost;
  assign green_x    = out_q[1].x;
  assign green_y    = out_q[1].y;
  assign blue_cost  = out_q[2].cost;
  assign blue_x     = out_q[2].x;
  assign blue_y     = out_q[2].y;
  assign found      = found_q;

endmodule

// File: tb/tb_color_locator.sv
// Directed bench for color_locator on a reduced 64x48 frame.
// Memory model paints up to three solid blocks on a uniform background.
module tb_color_locator;

  localparam int FW   = 64;
  localparam int FH   = 48;
  localparam int BLK  = 4;
  localparam int MG   = 2;
  localparam int LAT  = 2;
  localparam int NBLK = (FW / BLK - 2 * MG) * (FH / BLK - 2 * MG);
  localparam int SCAN = NBLK * (BLK * BLK + LAT + 2);

  typedef struct {
    logic [8:0]  bg;
    int          b0x, b0y; logic [8:0] c0;
    int          b1x, b1y; logic [8:0] c1;
    int          b2x, b2y; logic [8:0] c2;
    logic [31:0] minc;
    logic [31:0] rc, rx, ry;
    logic [31:0] gc, gx, gy;
    logic [31:0] bc, bx, by;
    logic [31:0] fnd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] min_cost;
  logic [8:0]  mem_pixel_data;
  logic        mem_request;
  logic [9:0]  mem_hcount, mem_vcount;
  logic        busy, done;
  logic [9:0]  red_x, red_y, green_x, green_y, blue_x, blue_y;
  logic [31:0] red_cost, green_cost, blue_cost;
  logic [2:0]  found;

  int checks = 0;
  int errors = 0;
  int cyc;
  vec_t cur;
  vec_t vecs[8];
  logic [8:0] pipe[LAT];

  always #5 clk = ~clk;

  color_locator #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .BLK     (BLK),
    .MARGIN  (MG),
    .MEM_LAT (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .min_cost       (min_cost),
    .mem_pixel_data (mem_pixel_data),
    .mem_request    (mem_request),
    .mem_hcount     (mem_hcount),
    .mem_vcount     (mem_vcount),
    .busy           (busy),
    .done           (done),
    .red_x          (red_x),
    .red_y          (red_y),
    .green_x        (green_x),
    .green_y        (green_y),
    .blue_x         (blue_x),
    .blue_y         (blue_y),
    .red_cost       (red_cost),
    .green_cost     (green_cost),
    .blue_cost      (blue_cost),
    .found          (found)
  );

  function automatic logic [8:0] img(input logic [9:0] h, input logic [9:0] v);
    int x, y;
    x = int'(h) / BLK;
    y = int'(v) / BLK;
    img = cur.bg;
    if (x == cur.b0x && y == cur.b0y) img = cur.c0;
    if (x == cur.b1x && y == cur.b1y) img = cur.c1;
    if (x == cur.b2x && y == cur.b2y) img = cur.c2;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= img(mem_hcount, mem_vcount);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_pixel_data = pipe[LAT-1];

  function automatic vec_t mkv(
    input logic [8:0] bg,
    input int b0x, input int b0y, input logic [8:0] c0,
    input int b1x, input int b1y, input logic [8:0] c1,
    input int b2x, input int b2y, input logic [8:0] c2,
    input logic [31:0] minc,
    input logic [31:0] rc, input logic [31:0] rx, input logic [31:0] ry,
    input logic [31:0] gc, input logic [31:0] gx, input logic [31:0] gy,
    input logic [31:0] bc, input logic [31:0] bx, input logic [31:0] by,
    input logic [31:0] fnd
  );
    vec_t v;
    v.bg = bg;
    v.b0x = b0x; v.b0y = b0y; v.c0 = c0;
    v.b1x = b1x; v.b1y = b1y; v.c1 = c1;
    v.b2x = b2x; v.b2y = b2y; v.c2 = c2;
    v.minc = minc;
    v.rc = rc; v.rx = rx; v.ry = ry;
    v.gc = gc; v.gx = gx; v.gy = gy;
    v.bc = bc; v.bx = bx; v.by = by;
    v.fnd = fnd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_results(input vec_t v, input string t);
    chk({t, ".rcost"}, red_cost, v.rc);
    chk({t, ".rx"}, 32'(red_x), v.rx);
    chk({t, ".ry"}, 32'(red_y), v.ry);
    chk({t, ".gcost"}, green_cost, v.gc);
    chk({t, ".gx"}, 32'(green_x), v.gx);
    chk({t, ".gy"}, 32'(green_y), v.gy);
    chk({t, ".bcost"}, blue_cost, v.bc);
    chk({t, ".bx"}, 32'(blue_x), v.bx);
    chk({t, ".by"}, 32'(blue_y), v.by);
    chk({t, ".found"}, 32'(found), v.fnd);
  endtask

  task automatic wait_done(input string t);
    while (done !== 1'b1 && cyc < SCAN + 500) tick();
    chk({t, ".latency"}, 32'(cyc), 32'(SCAN));
  endtask

  task automatic run_scan(input vec_t v, input string t);
    cur = v;
    @(negedge clk);
    min_cost = v.minc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    wait_done(t);
    chk_results(v, t);
    tick();
    chk({t, ".busy_after"}, 32'(busy), 32'd0);
    chk({t, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    min_cost = '0;
    cur = mkv(9'h000, -1, -1, 0, -1, -1, 0, -1, -1, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0] = mkv(9'h000, -1, -1, 0, -1, -1, 0, -1, -1, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    vecs[1] = mkv(9'h049, 10, 5, 9'h1C0, -1, -1, 0, -1, -1, 0, 0,
                  12544, 40, 20, 0, 0, 0, 0, 0, 0, 3'b100);
    vecs[2] = mkv(9'h049, 10, 5, 9'h1C0, -1, -1, 0, -1, -1, 0, 12545,
                  12544, 40, 20, 0, 0, 0, 0, 0, 0, 3'b000);
    vecs[3] = mkv(9'h049, 10, 5, 9'h1C0, -1, -1, 0, -1, -1, 0, 12544,
                  12544, 40, 20, 0, 0, 0, 0, 0, 0, 3'b100);
    vecs[4] = mkv(9'h000, 5, 5, 9'h038, 12, 5, 9'h038, -1, -1, 0, 1,
                  0, 0, 0, 12544, 20, 20, 0, 0, 0, 3'b010);
    vecs[5] = mkv(9'h000, 1, 4, 9'h007, -1, -1, 0, -1, -1, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    vecs[6] = mkv(9'h000, 6, 6, 9'h1F8, 3, 3, 9'h1C7, -1, -1, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    vecs[7] = mkv(9'h000, 2, 2, 9'h1C8, 7, 4, 9'h030, 13, 9, 9'h005, 9216,
                  10752, 8, 8, 9216, 28, 16, 6400, 52, 36, 3'b110);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.req", 32'(mem_request), 0);
    chk("rst.hcount", 32'(mem_hcount), 0);
    chk("rst.vcount", 32'(mem_vcount), 0);
    chk("rst.found", 32'(found), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    // address order, start-while-busy and output hold during a scan
    cur = vecs[1];
    @(negedge clk);
    min_cost = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    chk("addr.h0", 32'(mem_hcount), 8);
    chk("addr.v0", 32'(mem_vcount), 8);
    chk("addr.req", 32'(mem_request), 1);
    tick();
    chk("addr.h1", 32'(mem_hcount), 9);
    repeat (3) tick();
    chk("addr.h4", 32'(mem_hcount), 8);
    chk("addr.v4", 32'(mem_vcount), 9);
    while (cyc < 18) tick();
    chk("addr.cost_h", 32'(mem_hcount), 0);
    chk("addr.cost_v", 32'(mem_vcount), 0);
    tick();
    tick();
    chk("addr.blk2_h", 32'(mem_hcount), 12);
    chk("addr.blk2_v", 32'(mem_vcount), 8);
    while (cyc < 50) tick();
    start = 1'b1;
    min_cost = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    chk("hold.rcost", red_cost, 10752);
    chk("hold.gx", 32'(green_x), 28);
    chk("hold.found", 32'(found), 3'b110);
    wait_done("busy_start");
    chk_results(vecs[1], "busy_start");
    tick();

    // reset in the middle of a scan
    cur = vecs[1];
    @(negedge clk);
    min_cost = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid.busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", 32'(busy), 0);
    chk("mid.req", 32'(mem_request), 0);
    chk("mid.rcost", red_cost, 0);
    chk("mid.found", 32'(found), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("mid.no_done", 32'(seen), 0);
    run_scan(vecs[1], "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_locator.md
COLOR_LOCATOR -- requirements
Module: color_locator

Interface
REQ-001 Parameter FRAME_W, default 240: frame width in pixels; SHALL be a multiple of BLK.
REQ-002 Parameter FRAME_H, default 240: frame height in pixels; SHALL be a multiple of BLK.
REQ-003 Parameter BLK, default 4: block edge in pixels; SHALL be a power of two, 2..16.
REQ-004 Parameter MARGIN, default 2: number of border blocks skipped on every side.
REQ-005 Parameter MEM_LAT, default 2: fixed cycles from address to mem_pixel_data, 1..4.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle scan request; sampled only in IDLE.
REQ-009 min_cost  in  32  detection threshold; sampled at start.
REQ-010 mem_pixel_data  in  9  RGB 3:3:3 pixel: [8:6] R, [5:3] G, [2:0] B.
REQ-011 mem_request  out  1  high while a scan is in progress.
REQ-012 mem_hcount / mem_vcount  out  10 each  pixel address being read.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse at scan end.
REQ-015 red_x/red_y, green_x/green_y, blue_x/blue_y  out  10 each  top-left pixel of the winning block per channel.
REQ-016 red_cost/green_cost/blue_cost  out  32 each  winning cost per channel.
REQ-017 found  out  3  {R,G,B}: bit set when winning cost > 0 and >= min_cost.

Function
REQ-018 States: IDLE, FETCH, COST, UPDATE, DONE; IDLE->FETCH on start; DONE->IDLE unconditionally.
REQ-019 FETCH issues BLK*BLK addresses, one per cycle, raster order within the block (x fastest).
REQ-020 Each pixel arrives MEM_LAT cycles after its address; channel fields are accumulated into three sums of width 3+2*log2(BLK) bits, no saturation needed.
REQ-021 FETCH exits to COST on the cycle the last pixel is accumulated; sums clear at each block start.
REQ-022 COST: for channel a with others b,c, cost = (a-b)*(a-c) if a > b and a > c strictly, else 0; zero-extended to 32 bits.
REQ-023 UPDATE: a channel's winner (cost, x, y) is replaced only when the new cost is strictly greater; ties keep the earlier block.
REQ-024 Blocks are visited bx = MARGIN..FRAME_W/BLK-1-MARGIN fastest, then by over the same vertical range; bx wraps to MARGIN, not 0.
REQ-025 Reported x = bx*BLK, y = by*BLK.
REQ-026 UPDATE of the last block goes to DONE; otherwise to FETCH for the next block.
REQ-027 Per-block period SHALL be exactly BLK*BLK + MEM_LAT + 2 cycles.
REQ-028 DONE asserts done for one cycle, computes found, drops mem_request and busy on the following cycle.
REQ-029 Winner outputs and found change only in DONE; they hold the previous scan's values during a scan.
REQ-030 Winner accumulators and held min_cost clear at each accepted start.
REQ-031 start while busy is ignored; no queueing.
REQ-032 A channel never winning (all costs 0) reports cost 0, x = y = 0, found bit 0.
REQ-033 mem_hcount/mem_vcount are 0 outside FETCH.

Reset
REQ-034 rst_n low SHALL immediately force IDLE; all outputs 0, sums and accumulators 0.
REQ-035 Reset mid-scan abandons the scan with no done pulse; in-flight memory data is discarded.

Structure
REQ-036 A shared package SHALL hold the state encoding, the RGB 3:3:3 field positions, and the cost width (32).
REQ-037 One sub-module, block_accumulator: address generation, latency-aligned capture and channel sums for one block.

Verification
REQ-038 Frame all 0x000, min_cost 0, start -> done after 56*56*(16+4) cycles; costs 0, found 000, coords 0.
REQ-039 Block (10,20) pure red 9'h1C0 on grey 9'h049 -> red cost 112*112 = 12544, red_x 40, red_y 80, found[2] 1.
REQ-040 Two identical green blocks at (5,5) and (30,5) -> green_x 20 (earlier wins), green_y 20.
REQ-041 Strong blue block in border column bx=1 only -> blue cost 0, found[0] 0.
REQ-042 Red cost 12544, min_cost 12545 -> red_cost 12544 reported, found[2] 0; min_cost 12544 -> found[2] 1.
REQ-043 rst_n low 100 cycles into a scan, then start -> no done from the first scan; second scan completes with results identical to an uninterrupted scan.
